// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared prescaler encodings, terminal counts and synchroniser default for the frequency meter
package freq_meas_pkg;
    typedef enum logic [1:0] {
        DIV_1    = 2'b00,
        DIV_10   = 2'b01,
        DIV_100  = 2'b10,
        DIV_1000 = 2'b11
    } div_sel_e;
    localparam logic [9:0] TC_1 = 10'd0;
    localparam logic [9:0] TC_10 = 10'd9;
    localparam logic [9:0] TC_100 = 10'd99;
    localparam logic [9:0] TC_1000 = 10'd999;
    localparam int SYNC_STAGES_DEF = 2;
    function automatic logic [9:0] div_tc(input logic [1:0] sel);
        return sel == DIV_1 ? TC_1 : sel == DIV_10 ? TC_10 : sel == DIV_100 ? TC_100 : TC_1000;
    endfunction
endpackage

// File: rtl/sig_input_conditioner_if.sv
// sig_input_conditioner_if: control/status bundle of the input conditioner
// edge_sel exists only when FREQ_EDGE_SEL_EN is defined
interface sig_input_conditioner_if;
    logic signal_in;
    logic filt_en;
    logic [1:0] div_sel;
    logic gate_restart;
    logic count_en;
    logic sig_sync;
    logic no_signal;
`ifdef FREQ_EDGE_SEL_EN
    logic edge_sel;
    modport master(output signal_in, filt_en, div_sel, gate_restart, edge_sel, input count_en, sig_sync, no_signal);
    modport slave(input signal_in, filt_en, div_sel, gate_restart, edge_sel, output count_en, sig_sync, no_signal);
`else
    modport master(output signal_in, filt_en, div_sel, gate_restart, input count_en, sig_sync, no_signal);
    modport slave(input signal_in, filt_en, div_sel, gate_restart, output count_en, sig_sync, no_signal);
`endif
endinterface

// File: rtl/sig_glitch_filter.sv
// sig_glitch_filter: synchroniser chain followed by a consecutive-sample glitch filter
module sig_glitch_filter
    import freq_meas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN = 4
) (
    input  logic fpga_clk,
    input  logic nreset,
    input  logic filt_en,
    input  logic d,
    output logic q
);
    localparam logic [3:0] LIM = 4'(FILT_LEN - 1);
    logic [SYNC_STAGES-1:0] s;
    logic [3:0] cnt;
    logic s_last;
    logic mis;
    logic flip;
    assign s_last = s[SYNC_STAGES-1];
    assign mis = s_last != q;
    assign flip = mis && cnt == LIM;
    // cnt tracks how long the synchronised level has disagreed with q
    always_ff @(posedge fpga_clk or negedge nreset) begin
        if (!nreset) begin
            s <= '0;
            cnt <= '0;
            q <= 1'b0;
        end else begin
            s <= {s[SYNC_STAGES-2:0], d};
            q <= (!filt_en || flip) ? s_last : q;
            cnt <= (filt_en && mis && !flip) ? cnt + 4'd1 : 4'd0;
        end
    end
endmodule

// File: rtl/sig_input_conditioner.sv
// sig_input_conditioner: sync/filter, edge detect, decade prescaler and per-gate activity for the BCD counter
// FREQ_EDGE_SEL_EN adds edge_sel to count falling edges instead of rising ones
module sig_input_conditioner
    import freq_meas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN = 4
) (
    input logic fpga_clk,
    input logic nreset,
    sig_input_conditioner_if.slave bus
);
    logic filt;
    logic filt_d;
    logic edge_det;
    logic chg;
    logic cen;
    logic act;
    logic nosig;
    logic [1:0] div_q;
    logic [9:0] pc;
    logic [9:0] base;
    logic [9:0] tc;
    logic hit;
    sig_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt (
        .fpga_clk(fpga_clk),
        .nreset(nreset),
        .filt_en(bus.filt_en),
        .d(bus.signal_in),
        .q(filt)
    );
`ifdef FREQ_EDGE_SEL_EN
    logic sel_q;
    assign edge_det = sel_q ? (~filt & filt_d) : (filt & ~filt_d);
    assign chg = bus.div_sel != div_q || bus.edge_sel != sel_q;
    always_ff @(posedge fpga_clk or negedge nreset) begin
        if (!nreset) sel_q <= 1'b0;
        else sel_q <= bus.edge_sel;
    end
`else
    assign edge_det = filt & ~filt_d;
    assign chg = bus.div_sel != div_q;
`endif
    // a restart edge counts from zero so it becomes the first edge of the new gate
    assign tc = div_tc(div_q);
    assign base = bus.gate_restart ? 10'd0 : pc;
    assign hit = edge_det && base == tc;
    always_ff @(posedge fpga_clk or negedge nreset) begin
        if (!nreset) begin
            filt_d <= 1'b0;
            div_q <= DIV_1;
            pc <= '0;
            cen <= 1'b0;
            act <= 1'b0;
            nosig <= 1'b1;
        end else begin
            filt_d <= filt;
            div_q <= bus.div_sel;
            pc <= (chg || hit) ? 10'd0 : edge_det ? base + 10'd1 : base;
            cen <= !chg && hit;
            act <= bus.gate_restart ? edge_det : act | edge_det;
            nosig <= bus.gate_restart ? ~act : nosig;
        end
    end
    assign bus.count_en = cen;
    assign bus.sig_sync = filt;
    assign bus.no_signal = nosig;
endmodule

// File: tb/tb_sig_input_conditioner.sv
// tb_sig_input_conditioner: random and directed stimulus against a behavioural model of the conditioner
module tb_sig_input_conditioner;
    import freq_meas_pkg::*;
    localparam int SYNC = 2;
    localparam int FL = 4;
    logic fpga_clk = 1'b0;
    logic nreset = 1'b0;
    int vectors = 0;
    int errors = 0;
    int pulses = 0;
    bit sync_q[$];
    bit win[$];
    bit m_filt, m_filt_d, m_cen, m_act, m_nosig, m_esel;
    logic [1:0] m_div;
    int m_n;
    always #5 fpga_clk = ~fpga_clk;
    sig_input_conditioner_if bus();
    sig_input_conditioner #(.SYNC_STAGES(SYNC), .FILT_LEN(FL)) dut (
        .fpga_clk(fpga_clk),
        .nreset(nreset),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_of(input logic [1:0] s);
        return s == 2'd0 ? 1 : s == 2'd1 ? 10 : s == 2'd2 ? 100 : 1000;
    endfunction

    task automatic model_reset();
        sync_q = {};
        repeat (SYNC) sync_q.push_front(1'b0);
        win = {};
        m_filt = 0; m_filt_d = 0; m_cen = 0; m_act = 0; m_nosig = 1; m_esel = 0;
        m_div = 2'd0;
        m_n = 0;
    endtask

    // filtered level flips once the last FL synchronised samples all disagree with it
    task automatic model_edge();
        bit slast, nf, e, esel_in, all;
        slast = sync_q[SYNC-1];
        win.push_back(slast);
        if (win.size() > FL) void'(win.pop_front());
        all = win.size() == FL;
        foreach (win[i]) if (win[i] == m_filt) all = 0;
        nf = !bus.filt_en ? slast : all ? !m_filt : m_filt;
`ifdef FREQ_EDGE_SEL_EN
        esel_in = bus.edge_sel;
`else
        esel_in = 0;
`endif
        e = m_esel ? (!m_filt && m_filt_d) : (m_filt && !m_filt_d);
        m_cen = 0;
        if (bus.div_sel != m_div || esel_in != m_esel) m_n = 0;
        else begin
            if (bus.gate_restart) m_n = 0;
            if (e) begin
                m_n++;
                if (m_n == div_of(m_div)) begin
                    m_cen = 1;
                    m_n = 0;
                end
            end
        end
        if (bus.gate_restart) begin
            m_nosig = !m_act;
            m_act = e;
        end else m_act = m_act | e;
        m_div = bus.div_sel;
        m_esel = esel_in;
        m_filt_d = m_filt;
        m_filt = nf;
        sync_q.push_front(bus.signal_in);
        void'(sync_q.pop_back());
    endtask

    task automatic step();
        @(posedge fpga_clk);
        if (!nreset) model_reset();
        else model_edge();
        @(negedge fpga_clk);
        if (bus.count_en) pulses++;
        check("count_en", 32'(bus.count_en), 32'(m_cen));
        check("sig_sync", 32'(bus.sig_sync), 32'(m_filt));
        check("no_signal", 32'(bus.no_signal), 32'(m_nosig));
    endtask

    task automatic drive(input logic v, input int n);
        bus.signal_in = v;
        repeat (n) step();
    endtask

    task automatic pulse_train(input int n, input int hi, input int lo);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic gate();
        bus.gate_restart = 1'b1;
        step();
        bus.gate_restart = 1'b0;
    endtask

    task automatic latency(input string tag, input logic lvl, input int exp);
        int c;
        c = 0;
        bus.signal_in = lvl;
        do begin
            step();
            c++;
        end while (!bus.count_en && c < 20);
        check(tag, 32'(c), 32'(exp));
    endtask

    initial begin
        int len, gp, left;
        bit lvl;
        bus.signal_in = 0;
        bus.filt_en = 0;
        bus.div_sel = DIV_1;
        bus.gate_restart = 0;
`ifdef FREQ_EDGE_SEL_EN
        bus.edge_sel = 0;
`endif
        model_reset();
        repeat (3) step();
        check("rst_no_signal", 32'(bus.no_signal), 32'd1);
        nreset = 1'b1;
        drive(0, 5);
        latency("lat_nofilt", 1, SYNC + 2);
        drive(0, 15);
        pulses = 0;
        pulse_train(100, 5, 5);
        drive(0, 8);
        check("sq100", 32'(pulses), 32'd100);

        bus.filt_en = 1;
        drive(0, 10);
        latency("lat_filt", 1, SYNC + 2 + FL - 1);
        drive(0, 15);
        pulses = 0;
        pulse_train(20, 2, 6);
        drive(0, 10);
        check("glitch2", 32'(pulses), 32'd0);
        pulse_train(20, 4, 4);
        drive(0, 10);
        check("pulse4", 32'(pulses), 32'd20);

        bus.filt_en = 0;
        drive(0, 10);
        drive(1, 2);
        drive(0, 1);
        bus.signal_in = 1;
        nreset = 1'b0;
        #1;
        check("rst_async_count_en", 32'(bus.count_en), 32'd0);
        check("rst_async_sig_sync", 32'(bus.sig_sync), 32'd0);
        check("rst_async_no_signal", 32'(bus.no_signal), 32'd1);
        repeat (3) step();
        nreset = 1'b1;
        drive(0, 5);
        latency("lat_after_rst", 1, SYNC + 2);
        drive(0, 10);

        bus.div_sel = DIV_10;
        step();
        pulses = 0;
        pulse_train(95, 2, 2);
        drive(0, 8);
        check("div10_95", 32'(pulses), 32'd9);
        gate();
        check("nosig_active", 32'(bus.no_signal), 32'd0);
        pulses = 0;
        pulse_train(10, 2, 2);
        drive(0, 8);
        check("div10_gate", 32'(pulses), 32'd1);
        pulses = 0;
        pulse_train(4, 2, 2);
        bus.signal_in = 1;
        repeat (3) step();
        gate();
        drive(1, 1);
        drive(0, 2);
        pulse_train(9, 2, 2);
        drive(0, 8);
        check("coincident", 32'(pulses), 32'd1);
        gate();
        drive(0, 10);
        gate();
        check("nosig_idle", 32'(bus.no_signal), 32'd1);
        pulse_train(1, 2, 8);
        check("nosig_hold", 32'(bus.no_signal), 32'd1);
        gate();
        check("nosig_seen", 32'(bus.no_signal), 32'd0);

`ifdef FREQ_EDGE_SEL_EN
        bus.div_sel = DIV_1;
        bus.edge_sel = 1;
        drive(1, 10);
        latency("lat_fall", 0, SYNC + 2);
        pulses = 0;
        pulse_train(20, 3, 7);
        drive(0, 8);
        check("fall30", 32'(pulses), 32'd20);
        bus.div_sel = DIV_10;
        step();
        pulse_train(7, 2, 2);
        drive(0, 8);
        bus.edge_sel = 0;
        step();
        pulses = 0;
        pulse_train(9, 2, 2);
        drive(0, 8);
        check("esel_clear9", 32'(pulses), 32'd0);
        pulse_train(1, 2, 8);
        check("esel_clear10", 32'(pulses), 32'd1);
`endif

        for (int ph = 0; ph < 8; ph++) begin
            drive(0, 12);
            bus.div_sel = 2'(ph % 4);
            bus.filt_en = bus.div_sel == DIV_1000 ? 1'b0 : 1'($urandom_range(0, 1));
`ifdef FREQ_EDGE_SEL_EN
            bus.edge_sel = 1'($urandom_range(0, 1));
`endif
            len = bus.div_sel == DIV_1000 ? 3500 : 600;
            gp = bus.div_sel == DIV_1000 ? 0 : 40;
            left = 0;
            lvl = 0;
            for (int c = 0; c < len; c++) begin
                if (left == 0) begin
                    lvl = !lvl;
                    left = bus.filt_en ? $urandom_range(1, 8) : $urandom_range(1, 2);
                end
                left--;
                bus.signal_in = lvl;
                bus.gate_restart = gp != 0 && $urandom_range(1, gp) == 1;
                if (gp != 0 && $urandom_range(1, 300) == 1) bus.div_sel = 2'($urandom_range(0, 2));
`ifdef FREQ_EDGE_SEL_EN
                if (gp != 0 && $urandom_range(1, 300) == 1) bus.edge_sel = !bus.edge_sel;
`endif
                step();
            end
            bus.gate_restart = 0;
        end
        drive(0, 10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
